// File: rtl/apb_timer.sv
// APB slave with a prescaled 64-bit free-running counter, 64-bit compare and a sticky match interrupt.
// Access phase inserts WAIT_STATES cycles before a single-cycle pready; dropping psel in ACCESS aborts the transfer.
module apb_timer #(
  parameter int PRESCALE_W  = 16,
  parameter int WAIT_STATES = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] paddr,
  input  logic        psel,
  input  logic        penable,
  input  logic [2:0]  pprot,
  input  logic        pwrite,
  input  logic [31:0] pwdata,
  input  logic [3:0]  pstrb,
  output logic        pready,
  output logic [31:0] prdata,
  output logic        pslverr,
  output logic        irq
);

  localparam int WCW = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t                state_q, state_d;
  logic [WCW-1:0]        wait_cnt;
  logic [4:0]            lat_addr;
  logic                  lat_write;
  logic [31:0]           lat_wdata;
  logic [3:0]            lat_strb;

  logic [2:0]            ctrl;
  logic [PRESCALE_W-1:0] prescale;
  logic [PRESCALE_W-1:0] pre_cnt;
  logic [63:0]           count;
  logic [63:0]           cmp;
  logic                  match;
  logic [31:0]           hi_shadow;

  logic                  addr_err;
  logic                  wr_commit;
  logic                  rd_commit;
  logic [2:0]            sel;
  logic [31:0]           rdata;
  logic [31:0]           prescale_ext;
  logic                  tick;
  logic                  match_set;
  logic [63:0]           count_next;

  logic unused_inputs;
  assign unused_inputs = ^{paddr[31:5], pprot};

  function automatic logic [31:0] merge(input logic [31:0] old_val, input logic [31:0] wd,
                                        input logic [3:0] strb);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = wd[8*b +: 8];
    end
    return res;
  endfunction

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      wait_cnt  <= '0;
      lat_addr  <= '0;
      lat_write <= 1'b0;
      lat_wdata <= '0;
      lat_strb  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && psel && !penable) begin
        lat_addr  <= paddr[4:0];
        lat_write <= pwrite;
        lat_wdata <= pwdata;
        lat_strb  <= pstrb;
        wait_cnt  <= WCW'(WAIT_STATES);
      end else if (state_q == ACCESS && psel && penable && wait_cnt != '0) begin
        wait_cnt <= wait_cnt - 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    pready  = 1'b0;
    case (state_q)
      IDLE: begin
        if (psel && !penable) state_d = ACCESS;
      end
      ACCESS: begin
        if (!psel) begin
          state_d = IDLE;
        end else if (penable && wait_cnt == '0) begin
          pready  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign sel       = lat_addr[4:2];
  assign addr_err  = (lat_addr[1:0] != 2'b00) || (sel == 3'd7);
  assign wr_commit = pready && lat_write && !addr_err;
  assign rd_commit = pready && !lat_write && !addr_err;

  assign prescale_ext = {{(32-PRESCALE_W){1'b0}}, prescale};

  always_comb begin
    rdata = '0;
    case (sel)
      3'd0:    rdata = {29'b0, ctrl};
      3'd1:    rdata = prescale_ext;
      3'd2:    rdata = count[31:0];
      3'd3:    rdata = hi_shadow;
      3'd4:    rdata = cmp[31:0];
      3'd5:    rdata = cmp[63:32];
      3'd6:    rdata = {31'b0, match};
      default: rdata = '0;
    endcase
  end

  assign prdata  = (pready && !addr_err) ? rdata : 32'd0;
  assign pslverr = pready && addr_err;
  assign irq     = match & ctrl[1];

  assign tick      = ctrl[0] && (pre_cnt == prescale);
  assign match_set = ctrl[0] && (count == cmp);

  // Tick result first; a same-cycle COUNT write then overrides only its own half.
  always_comb begin
    count_next = count;
    if (tick) count_next = (ctrl[2] && count == cmp) ? 64'd0 : count + 64'd1;
    if (wr_commit && sel == 3'd2) count_next = {count_next[63:32], merge(count[31:0], lat_wdata, lat_strb)};
    if (wr_commit && sel == 3'd3) count_next = {merge(count[63:32], lat_wdata, lat_strb), count_next[31:0]};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ctrl      <= '0;
      prescale  <= '0;
      pre_cnt   <= '0;
      count     <= '0;
      cmp       <= '1;
      match     <= 1'b0;
      hi_shadow <= '0;
    end else begin
      count <= count_next;

      if (wr_commit && (sel == 3'd1 || sel == 3'd2 || sel == 3'd3)) pre_cnt <= '0;
      else if (tick)                                             pre_cnt <= '0;
      else if (ctrl[0])                                          pre_cnt <= pre_cnt + 1'b1;

      if (wr_commit && sel == 3'd0) ctrl <= merge({29'b0, ctrl}, lat_wdata, lat_strb)[2:0];
      if (wr_commit && sel == 3'd1) prescale <= merge(prescale_ext, lat_wdata, lat_strb)[PRESCALE_W-1:0];
      if (wr_commit && sel == 3'd4) cmp[31:0]  <= merge(cmp[31:0], lat_wdata, lat_strb);
      if (wr_commit && sel == 3'd5) cmp[63:32] <= merge(cmp[63:32], lat_wdata, lat_strb);

      if (match_set)                                                 match <= 1'b1;
      else if (wr_commit && sel == 3'd6 && lat_strb[0] && lat_wdata[0]) match <= 1'b0;

      if (rd_commit && sel == 3'd2) hi_shadow <= count[63:32];
    end
  end

endmodule

// File: tb/tb_apb_timer.sv
// Directed bench for apb_timer: register access, prescaled counting, wrap, HI shadow, errors, abort and reset.
module tb_apb_timer;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] paddr;
  logic        psel;
  logic        penable;
  logic [2:0]  pprot;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic        pready;
  logic [31:0] prdata;
  logic        pslverr;
  logic        irq;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] rdat;
  logic        rerr;
  int          rcyc;
  logic        seen;

  apb_timer #(.PRESCALE_W(16), .WAIT_STATES(1)) dut (
    .clock(clock), .reset(reset), .paddr(paddr), .psel(psel), .penable(penable),
    .pprot(pprot), .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb),
    .pready(pready), .prdata(prdata), .pslverr(pslverr), .irq(irq)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic apb(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                     input logic [3:0] strb);
    @(posedge clock); #1;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wd; pstrb = strb;
    @(posedge clock); #1;
    penable = 1'b1;
    rcyc = -1; rdat = '0; rerr = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clock);
      if (pready) begin
        rcyc = i; rdat = prdata; rerr = pslverr;
        break;
      end
    end
    check("pready_seen", {63'b0, pready}, 64'd1);
    @(posedge clock); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] wd);
    apb(1'b1, addr, wd, 4'hF);
  endtask

  task automatic rd(input logic [31:0] addr);
    apb(1'b0, addr, 32'd0, 4'h0);
  endtask

  initial begin
    reset = 1'b1; paddr = '0; psel = 0; penable = 0; pprot = '0; pwrite = 0; pwdata = '0; pstrb = '0;
    #1;
    check("rst_pready", {63'b0, pready}, 64'd0);
    check("rst_prdata", {32'b0, prdata}, 64'd0);
    check("rst_pslverr", {63'b0, pslverr}, 64'd0);
    check("rst_irq", {63'b0, irq}, 64'd0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;

    // Plain read of CTRL: pready on the second access cycle, then exactly one pulse.
    rd(32'h00);
    check("t1_cycle", 64'(rcyc), 64'd1);
    check("t1_prdata", {32'b0, rdat}, 64'd0);
    check("t1_pslverr", {63'b0, rerr}, 64'd0);
    @(negedge clock);
    check("t1_single_pulse", {63'b0, pready}, 64'd0);

    // Prescale 3, compare 10: COUNT reaches 10 forty edges after enable, MATCH one edge later.
    wr(32'h04, 32'd3);
    wr(32'h10, 32'd10);
    wr(32'h14, 32'd0);
    wr(32'h00, 32'h3);
    repeat (40) @(posedge clock);
    #1 check("t2_irq_before", {63'b0, irq}, 64'd0);
    @(posedge clock);
    #1 check("t2_irq_after", {63'b0, irq}, 64'd1);
    rd(32'h18);
    check("t2_status", {32'b0, rdat}, 64'd1);
    wr(32'h18, 32'd1);
    check("t2_irq_cleared", {63'b0, irq}, 64'd0);
    wr(32'h00, 32'h0);

    // 64-bit wrap with prescale 0.
    wr(32'h04, 32'd0);
    wr(32'h08, 32'hFFFF_FFFF);
    wr(32'h0C, 32'hFFFF_FFFF);
    wr(32'h00, 32'h1);
    rd(32'h08);
    check("t3_lo", {32'b0, rdat}, 64'd2);
    rd(32'h0C);
    check("t3_hi", {32'b0, rdat}, 64'd0);
    wr(32'h00, 32'h0);

    // Carry into the upper half between the LO and HI reads.
    wr(32'h08, 32'hFFFF_FFFC);
    wr(32'h0C, 32'h0);
    wr(32'h00, 32'h1);
    rd(32'h08);
    check("t4_lo", {32'b0, rdat}, 64'hFFFF_FFFF);
    rd(32'h0C);
    check("t4_hi_shadow", {32'b0, rdat}, 64'd0);
    rd(32'h08);
    rd(32'h0C);
    check("t4_hi_after", {32'b0, rdat}, 64'd1);
    wr(32'h00, 32'h0);

    // Error responses and byte strobes.
    rd(32'h1C);
    check("t5_rd_err", {63'b0, rerr}, 64'd1);
    check("t5_rd_data", {32'b0, rdat}, 64'd0);
    wr(32'h06, 32'd5);
    check("t5_wr_err", {63'b0, rerr}, 64'd1);
    rd(32'h04);
    check("t5_prescale_kept", {32'b0, rdat}, 64'd0);
    wr(32'h10, 32'hFFFF_FFFF);
    apb(1'b1, 32'h10, 32'hAABB_CCDD, 4'b0001);
    rd(32'h10);
    check("t5_strb", {32'b0, rdat}, 64'hFFFF_FFDD);

    // psel dropped in the wait state of a CTRL write.
    @(posedge clock); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h0; pwdata = 32'h7; pstrb = 4'hF;
    @(posedge clock); #1;
    psel = 1'b0; pwrite = 1'b0;
    seen = 1'b0;
    repeat (4) begin
      @(negedge clock);
      if (pready) seen = 1'b1;
    end
    check("t6_abort_pready", {63'b0, seen}, 64'd0);
    rd(32'h00);
    check("t6_ctrl_kept", {32'b0, rdat}, 64'd0);

    // Asynchronous reset during the pready cycle of a CMP_LO read.
    @(posedge clock); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'h10;
    @(posedge clock); #1;
    penable = 1'b1;
    @(negedge clock);
    @(negedge clock);
    check("t6_pre_reset_pready", {63'b0, pready}, 64'd1);
    #1 reset = 1'b1;
    #1 check("t6_reset_pready", {63'b0, pready}, 64'd0);
    psel = 1'b0; penable = 1'b0;
    @(posedge clock); #1 reset = 1'b0;
    rd(32'h10);
    check("t6_cmp_lo", {32'b0, rdat}, 64'hFFFF_FFFF);
    rd(32'h14);
    check("t6_cmp_hi", {32'b0, rdat}, 64'hFFFF_FFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
